// File: rtl/tap_host_ctrl.sv
// JTAG host controller: runs one IR or DR scan per command and returns the captured TDO bits.
// Optional TAP_HOST_RESET_SEQ_EN: drive Test-Logic-Reset then Run-Test/Idle after reset release.
module tap_host_ctrl #(
    parameter int DATA_W  = 32,
    parameter int CLK_DIV = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_ir_i,
    input  logic [$clog2(DATA_W):0] cmd_len_i,
    input  logic [DATA_W-1:0]       cmd_data_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_W-1:0]       rsp_data_o,
    output logic                    tck_o,
    output logic                    tms_o,
    output logic                    tdi_o,
    input  logic                    tdo_i,
    output logic [2:0]              dbg_state
);

    // Handshakes: a transfer happens on a clk_i edge where valid and ready are both high;
    // valid is held with its payload stable until that edge.

    localparam int LEN_W = $clog2(DATA_W) + 1;
    localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;
    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {RESET_SEQ, IDLE, PREFIX, SHIFT, SUFFIX, RESP} state_t;

    state_t             state;
    logic [DIV_W-1:0]   div;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   len_q;
    logic               ir_q;
    logic [DATA_W-1:0]  shreg;
    logic [LEN_W-1:0]   len_c;

    assign len_c     = (cmd_len_i > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len_i;
    assign dbg_state = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
`ifdef TAP_HOST_RESET_SEQ_EN
            state       <= RESET_SEQ;
`else
            state       <= IDLE;
`endif
            div         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            ir_q        <= 1'b0;
            shreg       <= '0;
            tck_o       <= 1'b0;
            tms_o       <= 1'b1;
            tdi_o       <= 1'b0;
            cmd_ready_o <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cmd_ready_o <= 1'b1;
                    tms_o       <= 1'b0;
                    if (cmd_valid_i && cmd_ready_o) begin
                        cmd_ready_o <= 1'b0;
                        ir_q        <= cmd_ir_i;
                        len_q       <= CNT_W'(len_c);
                        shreg       <= cmd_data_i;
                        rsp_data_o  <= '0;
                        div         <= '0;
                        cnt         <= '0;
                        if (len_c == '0) begin
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                        end else begin
                            state <= PREFIX;
                            tms_o <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (rsp_ready_i) begin
                        state       <= IDLE;
                        rsp_valid_o <= 1'b0;
                        cmd_ready_o <= 1'b1;
                    end
                end
                default: begin
                    // TCK engine: each phase lasts CLK_DIV clocks; TMS/TDI change only when TCK falls.
                    if (div != DIV_LAST) begin
                        div <= div + DIV_W'(1);
                    end else begin
                        div <= '0;
                        if (!tck_o) begin
                            tck_o <= 1'b1;
                            if (state == SHIFT)
                                rsp_data_o <= rsp_data_o | (DATA_W'(tdo_i) << cnt);
                        end else begin
                            tck_o <= 1'b0;
                            case (state)
                                RESET_SEQ: begin
                                    if (cnt == CNT_W'(5)) begin
                                        state       <= IDLE;
                                        cnt         <= '0;
                                        cmd_ready_o <= 1'b1;
                                        tms_o       <= 1'b0;
                                    end else begin
                                        cnt   <= cnt + CNT_W'(1);
                                        tms_o <= (cnt < CNT_W'(4));
                                    end
                                end
                                PREFIX: begin
                                    if (cnt == (ir_q ? CNT_W'(3) : CNT_W'(2))) begin
                                        state <= SHIFT;
                                        cnt   <= '0;
                                        tms_o <= (len_q == CNT_W'(1));
                                        tdi_o <= shreg[0];
                                        shreg <= shreg >> 1;
                                    end else begin
                                        cnt   <= cnt + CNT_W'(1);
                                        tms_o <= ir_q && (cnt == '0);
                                    end
                                end
                                SHIFT: begin
                                    if (cnt == len_q - CNT_W'(1)) begin
                                        state <= SUFFIX;
                                        cnt   <= '0;
                                        tms_o <= 1'b1;
                                        tdi_o <= 1'b0;
                                    end else begin
                                        cnt   <= cnt + CNT_W'(1);
                                        tms_o <= (cnt + CNT_W'(2) == len_q);
                                        tdi_o <= shreg[0];
                                        shreg <= shreg >> 1;
                                    end
                                end
                                default: begin
                                    // SUFFIX: Update (TMS=1, already driven) then Run-Test/Idle.
                                    if (cnt == '0) begin
                                        cnt   <= CNT_W'(1);
                                        tms_o <= 1'b0;
                                    end else begin
                                        state       <= RESP;
                                        cnt         <= '0;
                                        rsp_valid_o <= 1'b1;
                                    end
                                end
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tap_host_ctrl.sv
// Directed bench for tap_host_ctrl: a CLK_DIV=4 instance against a TAP target model
// (bypass DR, IR capture 0x1) and a CLK_DIV=1 instance with TDO looped back to TDI.
module tb_tap_host_ctrl;

    localparam int DW = 32;
    localparam int LW = $clog2(DW) + 1;
`ifdef TAP_HOST_RESET_SEQ_EN
    localparam int RST_RISES = 6;
`else
    localparam int RST_RISES = 0;
`endif

    localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHDR = 4, E1DR = 5, PDR = 6, E2DR = 7;
    localparam int UDR = 8, SIR = 9, CIR = 10, SHIR = 11, E1IR = 12, PIR = 13, E2IR = 14, UIR = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    logic          cmd_valid_a, cmd_ready_a, cmd_ir_a, rsp_valid_a, rsp_ready_a;
    logic [LW-1:0] cmd_len_a;
    logic [DW-1:0] cmd_data_a, rsp_data_a;
    logic          tck_a, tms_a, tdi_a;
    logic          tdo_a = 1'b0;
    logic [2:0]    state_a;

    logic          cmd_valid_b, cmd_ready_b, cmd_ir_b, rsp_valid_b, rsp_ready_b;
    logic [LW-1:0] cmd_len_b;
    logic [DW-1:0] cmd_data_b, rsp_data_b;
    logic          tck_b, tms_b, tdi_b, tdo_b;
    logic [2:0]    state_b;

    assign tdo_b = tdi_b;

    tap_host_ctrl #(.DATA_W(DW), .CLK_DIV(4)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_a), .cmd_ready_o(cmd_ready_a), .cmd_ir_i(cmd_ir_a),
        .cmd_len_i(cmd_len_a), .cmd_data_i(cmd_data_a),
        .rsp_valid_o(rsp_valid_a), .rsp_ready_i(rsp_ready_a), .rsp_data_o(rsp_data_a),
        .tck_o(tck_a), .tms_o(tms_a), .tdi_o(tdi_a), .tdo_i(tdo_a), .dbg_state(state_a)
    );

    tap_host_ctrl #(.DATA_W(DW), .CLK_DIV(1)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_n),
        .cmd_valid_i(cmd_valid_b), .cmd_ready_o(cmd_ready_b), .cmd_ir_i(cmd_ir_b),
        .cmd_len_i(cmd_len_b), .cmd_data_i(cmd_data_b),
        .rsp_valid_o(rsp_valid_b), .rsp_ready_i(rsp_ready_b), .rsp_data_o(rsp_data_b),
        .tck_o(tck_b), .tms_o(tms_b), .tdi_o(tdi_b), .tdo_i(tdo_b), .dbg_state(state_b)
    );

    // TAP target model for instance A
    function automatic int tap_next(input int s, input logic tms);
        case (s)
            TLR:  return tms ? TLR  : RTI;
            RTI:  return tms ? SDR  : RTI;
            SDR:  return tms ? SIR  : CDR;
            CDR:  return tms ? E1DR : SHDR;
            SHDR: return tms ? E1DR : SHDR;
            E1DR: return tms ? UDR  : PDR;
            PDR:  return tms ? E2DR : PDR;
            E2DR: return tms ? UDR  : SHDR;
            UDR:  return tms ? SDR  : RTI;
            SIR:  return tms ? TLR  : CIR;
            CIR:  return tms ? E1IR : SHIR;
            SHIR: return tms ? E1IR : SHIR;
            E1IR: return tms ? UIR  : PIR;
            PIR:  return tms ? E2IR : PIR;
            E2IR: return tms ? UIR  : SHIR;
            default: return tms ? SDR : RTI;
        endcase
    endfunction

    int         tap_st = RTI;
    logic       byp = 1'b0;
    logic [3:0] ir_sr = 4'h0;
    int         rises_a = 0;
    logic       tms_log [0:1023];

    always @(posedge tck_a or negedge rst_n) begin
        if (!rst_n) begin
            tap_st <= RTI;
        end else begin
            tms_log[rises_a % 1024] <= tms_a;
            rises_a <= rises_a + 1;
            if (tap_st == CDR)  byp   <= 1'b0;
            if (tap_st == SHDR) byp   <= tdi_a;
            if (tap_st == CIR)  ir_sr <= 4'b0001;
            if (tap_st == SHIR) ir_sr <= {tdi_a, ir_sr[3:1]};
            tap_st <= tap_next(tap_st, tms_a);
        end
    end

    always @(negedge tck_a)
        tdo_a <= (tap_st == SHDR) ? byp : (tap_st == SHIR) ? ir_sr[0] : 1'b0;

    // TCK period monitors, in clk cycles between rising edges
    int   nclk = 0;
    logic tck_prev_a = 1'b0, tck_prev_b = 1'b0;
    int   last_a = 0, last_b = 0, period_a = 0, period_b = 0, rises_b = 0;

    always @(negedge clk) begin
        nclk       <= nclk + 1;
        tck_prev_a <= tck_a;
        tck_prev_b <= tck_b;
        if (tck_a && !tck_prev_a) begin
            period_a <= nclk - last_a;
            last_a   <= nclk;
        end
        if (tck_b && !tck_prev_b) begin
            period_b <= nclk - last_b;
            last_b   <= nclk;
            rises_b  <= rises_b + 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] get_tms(input int base, input int n);
        logic [63:0] p = '0;
        for (int k = 0; k < n; k++) p[k] = tms_log[(base + k) % 1024];
        return p;
    endfunction

    task automatic send(input bit sel, input logic ir, input logic [LW-1:0] len, input logic [DW-1:0] data);
        int n = 0;
        while (!(sel ? cmd_ready_b : cmd_ready_a) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (sel) chk("b_ready_before_cmd", cmd_ready_b, 1'b1);
        else     chk("a_ready_before_cmd", cmd_ready_a, 1'b1);
        if (sel) begin
            cmd_valid_b = 1'b1; cmd_ir_b = ir; cmd_len_b = len; cmd_data_b = data;
        end else begin
            cmd_valid_a = 1'b1; cmd_ir_a = ir; cmd_len_a = len; cmd_data_a = data;
        end
        @(negedge clk);
        // Scramble the command bus after acceptance; the scan must not notice.
        if (sel) begin
            cmd_valid_b = 1'b0; cmd_ir_b = 1'($urandom_range(0, 1));
            cmd_len_b = LW'($urandom_range(0, 40)); cmd_data_b = $urandom();
        end else begin
            cmd_valid_a = 1'b0; cmd_ir_a = 1'($urandom_range(0, 1));
            cmd_len_a = LW'($urandom_range(0, 40)); cmd_data_a = $urandom();
        end
    endtask

    task automatic scan(input bit sel, input string tag, input logic ir, input logic [LW-1:0] len,
                        input logic [DW-1:0] data, input logic [DW-1:0] exp_rsp, input int exp_rises,
                        input int lat_min, input int lat_max, output int base);
        int n = 0;
        base = sel ? rises_b : rises_a;
        send(sel, ir, len, data);
        while (!(sel ? rsp_valid_b : rsp_valid_a) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_valid"}, sel ? rsp_valid_b : rsp_valid_a, 1'b1);
        chk({tag, "_latency_in_range"}, (n >= lat_min) && (n <= lat_max), 1'b1);
        chk({tag, "_rsp"}, sel ? rsp_data_b : rsp_data_a, exp_rsp);
        chk({tag, "_tck_cycles"}, (sel ? rises_b : rises_a) - base, exp_rises);
    endtask

    task automatic ack(input bit sel);
        if (sel) rsp_ready_b = 1'b1; else rsp_ready_a = 1'b1;
        @(negedge clk);
        rsp_ready_a = 1'b0;
        rsp_ready_b = 1'b0;
        if (sel) chk("b_ack_valid_low", rsp_valid_b, 1'b0);
        else     chk("a_ack_valid_low", rsp_valid_a, 1'b0);
    endtask

    task automatic post_reset(input string tag);
        int n = 0;
        int base = rises_a;
        while (!cmd_ready_a && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready"}, cmd_ready_a, 1'b1);
        chk({tag, "_tck_cycles"}, rises_a - base, RST_RISES);
        chk({tag, "_tms_idle"}, tms_a, 1'b0);
        chk({tag, "_no_rsp"}, rsp_valid_a, 1'b0);
`ifdef TAP_HOST_RESET_SEQ_EN
        chk({tag, "_tms_seq"}, get_tms(base, 6), 64'h1F);
`endif
    endtask

    initial begin
        int base;
        int n;
        logic hold_ok;
        logic [DW-1:0] d;

        cmd_valid_a = 0; cmd_ir_a = 0; cmd_len_a = '0; cmd_data_a = '0; rsp_ready_a = 0;
        cmd_valid_b = 0; cmd_ir_b = 0; cmd_len_b = '0; cmd_data_b = '0; rsp_ready_b = 0;
        repeat (3) @(negedge clk);
        chk("reset_tck", tck_a, 1'b0);
        chk("reset_tms", tms_a, 1'b1);
        chk("reset_tdi", tdi_a, 1'b0);
        chk("reset_cmd_ready", cmd_ready_a, 1'b0);
        chk("reset_rsp_valid", rsp_valid_a, 1'b0);
        chk("reset_rsp_data", rsp_data_a, 32'h0);
        rst_n = 1'b1;
        post_reset("post_reset");

        // DR bypass: 13 TCK cycles of 8 clocks each
        scan(0, "dr8", 1'b0, LW'(8), 32'hAB, 32'h56, 13, 104, 104, base);
        chk("dr8_tms_seq", get_tms(base, 13), 64'h0C01);
        chk("a_tck_period", period_a, 8);
        ack(0);

        // IR scan with capture 0x1, then hold the response for 20 cycles
        scan(0, "ir4", 1'b1, LW'(4), 32'h5, 32'h1, 10, 80, 80, base);
        chk("ir4_tms_seq", get_tms(base, 10), 64'h0183);
        cmd_valid_a = 1'b1; cmd_ir_a = 1'b0; cmd_len_a = LW'(8); cmd_data_a = 32'hFF;
        base = rises_a;
        hold_ok = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!(rsp_valid_a === 1'b1 && rsp_data_a === 32'h1 && cmd_ready_a === 1'b0)) hold_ok = 1'b0;
        end
        chk("hold_stable", hold_ok, 1'b1);
        chk("hold_no_accept", rises_a - base, 0);
        cmd_valid_a = 1'b0;
        ack(0);

        scan(0, "len0", 1'b0, LW'(0), 32'hFFFF_FFFF, 32'h0, 0, 0, 2, base);
        ack(0);

        scan(0, "len1", 1'b0, LW'(1), 32'h1, 32'h0, 6, 48, 48, base);
        chk("len1_tms_seq", get_tms(base, 6), 64'h19);
        ack(0);

        scan(0, "clamp40", 1'b0, LW'(40), 32'h8000_0001, 32'h2, 37, 296, 296, base);
        ack(0);

        // CLK_DIV=1 loopback: full width, no bit lost
        d = $urandom();
        scan(1, "loop32", 1'b0, LW'(32), d, d, 37, 74, 74, base);
        chk("b_tck_period", period_b, 2);
        ack(1);
        scan(1, "loop5", 1'b1, LW'(5), 32'hFFFF_FFFF, 32'h1F, 11, 22, 22, base);
        ack(1);

        // Reset in the middle of SHIFT
        base = rises_a;
        send(0, 1'b0, LW'(16), 32'h1234);
        n = 0;
        while ((rises_a - base) < 6 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("abort_reached_shift", (rises_a - base) >= 6, 1'b1);
        chk("abort_tck_high_before", tck_a, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_tck", tck_a, 1'b0);
        chk("abort_tms", tms_a, 1'b1);
        chk("abort_rsp_valid", rsp_valid_a, 1'b0);
        chk("abort_rsp_data", rsp_data_a, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        post_reset("abort_recover");
        chk("abort_rsp_data_after", rsp_data_a, 32'h0);

        scan(0, "dr8_after_abort", 1'b0, LW'(8), 32'h3C, 32'h78, 13, 104, 104, base);
        ack(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_host_ctrl.md
TAP_HOST_CTRL -- requirements
Module: tap_host_ctrl

Interface
REQ-001 SHALL provide parameter DATA_W, default 32: maximum shift length and width of the data buses.
REQ-002 SHALL provide parameter CLK_DIV, default 4: TCK half-period in clk_i cycles, minimum 1.
REQ-003 SHALL provide port clk_i, input, 1 bit: system clock, sole clock.
REQ-004 SHALL provide port rst_ni, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL provide port cmd_valid_i, input, 1 bit: command request.
REQ-006 SHALL provide port cmd_ready_o, output, 1 bit: command accepted when high together with cmd_valid_i.
REQ-007 SHALL provide port cmd_ir_i, input, 1 bit: 1 selects an IR scan, 0 selects a DR scan.
REQ-008 SHALL provide port cmd_len_i, input, $clog2(DATA_W)+1 bits: number of bits to shift, 0..DATA_W.
REQ-009 SHALL provide port cmd_data_i, input, DATA_W bits: TDI data, shifted LSB first.
REQ-010 SHALL provide port rsp_valid_o, output, 1 bit: captured data available.
REQ-011 SHALL provide port rsp_ready_i, input, 1 bit: response consumed.
REQ-012 SHALL provide port rsp_data_o, output, DATA_W bits: captured TDO bits, right-aligned.
REQ-013 SHALL provide ports tck_o, tms_o and tdi_o, outputs, 1 bit each: JTAG pins driven to the target.
REQ-014 SHALL provide port tdo_i, input, 1 bit: JTAG TDO from the target.

Function
REQ-015 SHALL idle tck_o low; each TCK cycle SHALL be CLK_DIV clk_i cycles low followed by CLK_DIV clk_i cycles high.
REQ-016 SHALL update tms_o and tdi_o only at the start of a TCK low phase, and SHALL sample tdo_i on the clk_i edge that raises tck_o.
REQ-017 SHALL assert cmd_ready_o only in state IDLE when rsp_valid_o is low.
REQ-018 SHALL execute a DR scan with the TMS sequence 1,0,0 (Select-DR, Capture-DR, Shift-DR), then len shift cycles with TMS=0 except the last at TMS=1 (Exit1-DR), then 1,0 (Update-DR, Run-Test/Idle): len+5 TCK cycles in total.
REQ-019 SHALL execute an IR scan identically, with prefix 1,1,0,0: len+6 TCK cycles in total.
REQ-020 SHALL drive tdi_o=cmd_data_i[i] during shift cycle i and SHALL store TDO sampled in cycle i into rsp_data_o[i]; bits at len and above SHALL be 0.
REQ-021 SHALL, for len=0, generate no TCK pulses and return rsp_data_o=0.
REQ-022 SHALL, for len>DATA_W, clamp the shift length to DATA_W.
REQ-023 SHALL drive tdi_o low outside shift cycles.
REQ-024 SHALL register the command at acceptance; changes on cmd_* inputs during a scan SHALL have no effect.
REQ-025 SHALL raise rsp_valid_o on the clk_i cycle after the final TCK high phase ends and SHALL hold it, with rsp_data_o stable, until rsp_ready_i is sampled high.
REQ-026 SHALL use the states RESET_SEQ, IDLE, PREFIX, SHIFT, SUFFIX and RESP; RESP SHALL return to IDLE on rsp_ready_i.

Reset
REQ-027 SHALL, while rst_ni is low, force tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=0, rsp_valid_o=0 and rsp_data_o=0.
REQ-028 SHALL, on assertion of rst_ni mid-scan, abort the scan immediately and discard any partial response.

Configuration
REQ-029 SHALL, when TAP_HOST_RESET_SEQ_EN is defined, perform after reset release 5 TCK cycles with TMS=1 (Test-Logic-Reset) then 1 cycle with TMS=0 (Run-Test/Idle) in state RESET_SEQ before entering IDLE.
REQ-030 SHALL, when TAP_HOST_RESET_SEQ_EN is undefined, enter IDLE on the first clk_i cycle after reset release with tms_o=0, and omit RESET_SEQ.

Verification
REQ-031 SHALL check: DR scan, len=8, data=0xAB, against a target model in bypass (capture 0, 1-bit delay) -> rsp_data_o=0x56 after 13 TCK cycles.
REQ-032 SHALL check: IR scan, len=4, data=0x5, against a target model with IR capture 0x1 -> TMS=1,1,0,0,0,0,0,1,1,0 and rsp_data_o=0x1.
REQ-033 SHALL check: len=0 -> no tck_o rising edge and rsp_valid_o within 2 cycles with rsp_data_o=0.
REQ-034 SHALL check: rsp_ready_i held low for 20 cycles -> rsp_valid_o and rsp_data_o stable, cmd_ready_o low, and a new cmd_valid_i not accepted.
REQ-035 SHALL check: rst_ni pulsed low during SHIFT -> tck_o=0 and tms_o=1 immediately; with TAP_HOST_RESET_SEQ_EN defined, 5 TMS-high cycles and 1 TMS-low cycle occur before cmd_ready_o=1.
REQ-036 SHALL check: CLK_DIV=1 and CLK_DIV=4 with len=DATA_W -> TCK cycle of 2 and 8 clk_i cycles, and no data bit lost.
